// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared constants, state type and step helper for sprite motion controllers.
// Build option SPRITE_WRAP_EN: defined gives a toroidal screen, undefined clamps at the edges.
package sprite_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 64;
  localparam int SPRITE_H = 64;
  localparam logic [9:0] MAX_X = 10'(SCREEN_W - SPRITE_W);
  localparam logic [9:0] MAX_Y = 10'(SCREEN_H - SPRITE_H);

  typedef enum logic [1:0] {IDLE, HOLD, MOVE} motion_state_t;

  // One axis step; opposite directions pressed together cancel.
  function automatic logic [9:0] step_axis(input logic [9:0] pos, input logic inc,
                                           input logic dec, input logic [9:0] step,
                                           input logic [9:0] lim);
    logic signed [10:0] n;
    n = $signed({1'b0, pos});
    if (inc && !dec)      n = n + $signed({1'b0, step});
    else if (dec && !inc) n = n - $signed({1'b0, step});
`ifdef SPRITE_WRAP_EN
    if (n[10])                          return lim;
    else if (n > $signed({1'b0, lim}))  return 10'd0;
    else                                return n[9:0];
`else
    if (n[10])                          return 10'd0;
    else if (n > $signed({1'b0, lim}))  return lim;
    else                                return n[9:0];
`endif
  endfunction
endpackage

// File: rtl/sprite_motion_ctrl_frame_tick_gen.sv
// One-cycle pulse on the rising edge of (pixelx==0 && pixely==SCREEN_H).
module frame_tick_gen #(
  parameter int SCREEN_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] i_pixelx,
  input  logic [9:0] i_pixely,
  output logic       o_tick
);
  logic w_cond;
  logic r_cond_q;
  logic r_tick;

  assign w_cond = (i_pixelx == 10'd0) && (i_pixely == 10'(SCREEN_H));

  // r_cond_q resets high so a cond level present at release is not taken as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cond_q <= 1'b1;
      r_tick   <= 1'b0;
    end else begin
      r_cond_q <= w_cond;
      r_tick   <= w_cond & ~r_cond_q;
    end
  end

  assign o_tick = r_tick;
endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position controller: synced buttons -> IDLE/HOLD/MOVE -> posx/posy at vblank.
// Edge behaviour selected by SPRITE_WRAP_EN (wrap) vs default (clamp).
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int SCREEN_W    = sprite_pkg::SCREEN_W,
  parameter int SCREEN_H    = sprite_pkg::SCREEN_H,
  parameter int SPRITE_W    = sprite_pkg::SPRITE_W,
  parameter int SPRITE_H    = sprite_pkg::SPRITE_H,
  parameter int STEP        = 4,
  parameter int HOLD_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pixelx,
  input  logic [9:0] pixely,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       frame_tick,
  output logic       moving
);
  localparam logic [9:0] L_MAX_X = 10'(SCREEN_W - SPRITE_W);
  localparam logic [9:0] L_MAX_Y = 10'(SCREEN_H - SPRITE_H);
  localparam logic [9:0] L_RST_X = 10'((SCREEN_W - SPRITE_W) / 2);
  localparam logic [9:0] L_RST_Y = 10'((SCREEN_H - SPRITE_H) / 2);
  localparam int         CW      = $clog2(HOLD_FRAMES + 1);

  logic [3:0]    r_sync1, r_sync2;
  logic          w_up, w_dn, w_lf, w_rt, w_active, w_tick;
  logic [9:0]    w_nx, w_ny;
  logic [9:0]    r_posx, r_posy;
  logic          r_moving;
  logic [CW-1:0] r_cnt;
  motion_state_t r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {btn_up, btn_down, btn_left, btn_right};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_up, w_dn, w_lf, w_rt} = r_sync2;
  assign w_active = (w_rt ^ w_lf) | (w_dn ^ w_up);
  assign w_nx     = step_axis(r_posx, w_rt, w_lf, 10'(STEP), L_MAX_X);
  assign w_ny     = step_axis(r_posy, w_dn, w_up, 10'(STEP), L_MAX_Y);

  frame_tick_gen #(.SCREEN_H(SCREEN_H)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .i_pixelx (pixelx),
    .i_pixely (pixely),
    .o_tick   (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_posx   <= L_RST_X;
      r_posy   <= L_RST_Y;
      r_moving <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        IDLE: if (w_active) begin
          r_posx  <= w_nx;
          r_posy  <= w_ny;
          r_state <= HOLD;
          r_cnt   <= CW'(1);
        end
        HOLD: begin
          if (!w_active) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CW'(HOLD_FRAMES)) begin
            r_posx   <= w_nx;
            r_posy   <= w_ny;
            r_state  <= MOVE;
            r_moving <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        MOVE: begin
          if (w_active) begin
            r_posx <= w_nx;
            r_posy <= w_ny;
          end else begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_moving <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_cnt    <= '0;
          r_moving <= 1'b0;
        end
      endcase
    end
  end

  assign posx       = r_posx;
  assign posy       = r_posy;
  assign moving     = r_moving;
  assign frame_tick = w_tick;
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: short synthetic frames, expected positions queued per tick.
module tb_sprite_motion_ctrl;
  localparam logic [3:0] B_NO = 4'b0000, B_UP = 4'b1000, B_DN = 4'b0100,
                         B_LF = 4'b0010, B_RT = 4'b0001;

  typedef struct {logic [3:0] btn; int ex; int ey; logic em;} vec_t;
  typedef struct {int ex; int ey; logic em;} exp_t;

  logic       clk = 0, rst = 1;
  logic [9:0] pixelx = 10'd0, pixely = 10'd480;
  logic       btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic [9:0] posx, posy;
  logic       frame_tick, moving;

  int   n_vec = 0, n_err = 0, ticks = 0;
  int   ex, ey, t0, keep;
  bit   pend = 0;
  exp_t q[$];
  vec_t tbl[26];

  sprite_motion_ctrl dut (
    .clk(clk), .rst(rst), .pixelx(pixelx), .pixely(pixely),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .posx(posx), .posy(posy), .frame_tick(frame_tick), .moving(moving)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int stp(int v, int d, int lim);
    int n;
    n = v + 4 * d;
`ifdef SPRITE_WRAP_EN
    if (n < 0) return lim;
    if (n > lim) return 0;
`else
    if (n < 0) return 0;
    if (n > lim) return lim;
`endif
    return n;
  endfunction

  // Cycle after each tick: pop the expectation queued when that frame was driven.
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      pend = 0;
      if (q.size() == 0) chk("queue_underflow", 1, 0);
      else begin
        e = q.pop_front();
        chk("posx", int'(posx), e.ex);
        chk("posy", int'(posy), e.ey);
        chk("moving", int'(moving), int'(e.em));
      end
    end
    if (frame_tick === 1'b1) begin
      ticks++;
      pend = 1;
    end
  end

  task automatic frame(input logic [3:0] b, input int fx, input int fy, input logic fm);
    exp_t e;
    e.ex = fx; e.ey = fy; e.em = fm;
    q.push_back(e);
    {btn_up, btn_down, btn_left, btn_right} = b;
    pixelx = 10'd5; pixely = 10'd5;
    repeat (4) @(negedge clk);
    pixelx = 10'd0; pixely = 10'd480;   // held two cycles: still only one tick
    repeat (2) @(negedge clk);
    pixelx = 10'd5; pixely = 10'd5;
    repeat (3) @(negedge clk);
  endtask

  // Hold b for n ticks from IDLE, tracking expected position in ex/ey.
  task automatic run_hold(input logic [3:0] b, input int dx, input int dy, input int n,
                          input bit rel);
    for (int k = 1; k <= n; k++) begin
      if (k == 1 || k >= 9) begin
        ex = stp(ex, dx, 576);
        ey = stp(ey, dy, 416);
      end
      frame(b, ex, ey, k >= 9);
    end
    if (rel) frame(B_NO, ex, ey, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) tbl[i] = '{B_NO, 288, 208, 1'b0};
    tbl[3] = '{B_RT, 292, 208, 1'b0};
    tbl[4] = '{B_NO, 292, 208, 1'b0};
    for (int k = 1; k <= 20; k++)
      tbl[4 + k] = '{B_DN, 292, (k < 9) ? 212 : 216 + 4 * (k - 9), k >= 9};
    tbl[25] = '{B_NO, 292, 260, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_posx", int'(posx), 288);
    chk("rst_posy", int'(posy), 208);
    chk("rst_moving", int'(moving), 0);
    chk("rst_tick", int'(frame_tick), 0);
    rst = 0;  // cond already high at release: no tick until a fresh edge
    repeat (5) @(negedge clk);
    chk("no_tick_at_release", ticks, 0);

    for (int i = 0; i < 26; i++) begin
      frame(tbl[i].btn, tbl[i].ex, tbl[i].ey, tbl[i].em);
      if (i == 2) chk("idle_tick_count", ticks, 3);
    end
    chk("table_tick_count", ticks, 26);

    ex = 292; ey = 260;
    run_hold(B_RT, 1, 0, 90, 1);
`ifndef SPRITE_WRAP_EN
    chk("sat_right", int'(posx), 576);
`endif
    run_hold(B_LF, -1, 0, 160, 1);
`ifndef SPRITE_WRAP_EN
    chk("sat_left", int'(posx), 0);
`endif
    keep = ex;
    run_hold(B_UP | B_LF | B_RT, 0, -1, 80, 1);
    chk("conflict_x", int'(posx), keep);
`ifndef SPRITE_WRAP_EN
    chk("sat_up", int'(posy), 0);
`endif

    run_hold(B_DN, 0, 1, 12, 0);
    @(negedge clk);
    pixelx = 10'd0; pixely = 10'd480;
    @(posedge clk);
    #2;
    chk("tick_in_flight", int'(frame_tick), 1);
    chk("moving_pre_rst", int'(moving), 1);
    rst = 1;
    #1;
    chk("arst_posx", int'(posx), 288);
    chk("arst_posy", int'(posy), 208);
    chk("arst_moving", int'(moving), 0);
    chk("arst_tick", int'(frame_tick), 0);
    repeat (3) @(negedge clk);
    rst = 0;
    t0 = ticks;
    repeat (4) @(negedge clk);
    chk("no_tick_after_rst", ticks - t0, 0);
    frame(B_DN, 288, 212, 1'b0);
    frame(B_NO, 288, 212, 1'b0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
